// File: rtl/aes_mc_pkg.sv
// Shared definitions for the iterative AES MixColumns engine:
// FSM encoding, field constants and the GF(2^8) doubling helper.
package aes_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NB_COL   = 4;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mc_col_dual.sv
// Combinational MixColumns / InvMixColumns for one 32-bit column.
// Inverse reuses the forward network after a cheap pre-transform.
module aes_mc_col_dual
  import aes_mc_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic       inv_g;
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] u, v;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    inv_g = inv & (INV_EN != 0);
    a0 = col_in[7:0];
    a1 = col_in[15:8];
    a2 = col_in[23:16];
    a3 = col_in[31:24];
    // multiply-by-4 terms that turn the forward matrix into the inverse one
    u = xtime(xtime(a0 ^ a2));
    v = xtime(xtime(a1 ^ a3));
    b0 = inv_g ? (a0 ^ u) : a0;
    b1 = inv_g ? (a1 ^ v) : a1;
    b2 = inv_g ? (a2 ^ u) : a2;
    b3 = inv_g ? (a3 ^ v) : a3;
    col_out[7:0]   = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
    col_out[15:8]  = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
    col_out[23:16] = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
    col_out[31:24] = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
  end

endmodule

// File: rtl/aes_mc_iter.sv
// Iterative MixColumns engine: transforms NCOL columns of a 128-bit AES
// state per cycle in place, with valid/ready handshakes on both sides.
module aes_mc_iter
  import aes_mc_pkg::*;
#(
  parameter int NCOL   = 1,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int NGRP  = NB_COL / NCOL;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int GRP_W = 32 * NCOL;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

  if (NCOL != 1 && NCOL != 2 && NCOL != 4) begin : g_bad_ncol
    $fatal(1, "aes_mc_iter: NCOL must be 1, 2 or 4");
  end

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [127:0]       work_q, work_d;
  logic [GRP_W-1:0]   grp_in, grp_out;
  logic               accept;

  assign grp_in = work_q[int'(cnt_q) * GRP_W +: GRP_W];

  for (genvar g = 0; g < NCOL; g++) begin : g_col
    aes_mc_col_dual #(.INV_EN(INV_EN)) u_col (
      .col_in (grp_in[32*g +: 32]),
      .inv    (mode_q),
      .col_out(grp_out[32*g +: 32])
    );
  end

  // in_ready in DONE follows out_ready so a new state can enter while draining
  assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign out_state = (state_q == ST_DONE) ? work_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    accept  = in_valid & in_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          work_d  = in_state;
          mode_d  = in_inv;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d[int'(cnt_q) * GRP_W +: GRP_W] = grp_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept) begin
          work_d  = in_state;
          mode_d  = in_inv;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // data register carries no reset; out_state is masked outside DONE
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

endmodule

// File: tb/tb_aes_mc_iter.sv
// Scoreboard bench for aes_mc_iter: four instances (NCOL=1,2,4 and NCOL=4
// without inverse) share stimulus; one is selected at a time.
module tb_aes_mc_iter;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         in_valid_c = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic [1:0]   sel = 2'd0;

  logic         in_valid_a [NDUT];
  logic         in_ready_a [NDUT];
  logic         out_valid_a[NDUT];
  logic [127:0] out_state_a[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign in_valid_a[g] = in_valid_c && (sel == g);
    aes_mc_iter #(
      .NCOL  ((g == 0) ? 1 : (g == 1) ? 2 : 4),
      .INV_EN((g == 3) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .in_state (in_state),
      .in_inv   (in_inv),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready),
      .out_state(out_state_a[g])
    );
  end

  logic         in_ready_s, out_valid_s;
  logic [127:0] out_state_s;
  assign in_ready_s  = in_ready_a[sel];
  assign out_valid_s = out_valid_a[sel];
  assign out_state_s = out_state_a[sel];

  function automatic int lat_of(input logic [1:0] k);
    int ncol;
    ncol = (k == 2'd0) ? 1 : (k == 2'd1) ? 2 : 4;
    return 4 / ncol + 1;
  endfunction

  function automatic logic inv_en_of(input logic [1:0] k);
    return (k != 2'd3);
  endfunction

  // reference model: generic GF(2^8) multiply and the AES matrices
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mc(input logic [127:0] s, input logic inv);
    logic [7:0]   m[4];
    logic [7:0]   y;
    logic [127:0] r;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        y = 8'h00;
        for (int k = 0; k < 4; k++) y ^= gmul(s[32*c + 8*k +: 8], m[(k - row + 4) % 4]);
        r[32*c + 8*row +: 8] = y;
      end
    return r;
  endfunction

  typedef struct {
    logic [127:0] d;
    int           acc;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int or_mode = 0;  // 0: out_ready high, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (dut %0d, cycle %0d)", name, act, exp, sel, cyc);
    end
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid_s && !prev_v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 with nothing outstanding (dut %0d, cycle %0d)", sel, cyc);
        end else begin
          chk("latency", 128'(cyc - q[0].acc), 128'(lat_of(sel)));
        end
      end
      if (out_valid_s && out_ready && q.size() != 0) begin
        chk("out_state", out_state_s, q[0].d);
        void'(q.pop_front());
      end
      prev_v = out_valid_s;
    end
  end

  // caller is at posedge+1; returns at posedge+1 right after the accept edge
  task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] e);
    int   n;
    logic acc;
    in_valid_c = 1'b1;
    in_state   = s;
    in_inv     = inv;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_s;
      if (acc) q.push_back('{d: e, acc: cyc});
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_c = 1'b0;
    in_state   = {$urandom, $urandom, $urandom, $urandom};
    in_inv     = 1'($urandom_range(0, 1));
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles (dut %0d)", sel);
    end
  endtask

  task automatic drain();
    int n;
    or_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results never arrived (dut %0d)", q.size(), sel);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V_IN  = {32'h4c31262d, 32'hd5d4d4d4, 32'hc6c6c6c6, 32'h5c220af2};
  localparam logic [127:0] V_OUT = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'hc6c6c6c6, 32'h9d58dc9f};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, f;
    logic         inv;
    int           n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      sel = 2'(k);
      #1;
      chk("rst_in_ready", 128'(in_ready_s), 128'(0));
      chk("rst_out_valid", 128'(out_valid_s), 128'(0));
      chk("rst_out_state", out_state_s, 128'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      sel = 2'(k);
      #1;
      chk("idle_in_ready", 128'(in_ready_s), 128'(1));
    end
    @(posedge clk);
    #1;

    sel = 2'd0;
    send({4{32'h455313db}}, 1'b0, {4{32'hbca14d8e}});
    drain();
    sel = 2'd1;
    send(V_IN, 1'b0, V_OUT);
    drain();
    sel = 2'd2;
    send(V_OUT, 1'b1, V_IN);
    drain();
    sel = 2'd3;
    send(V_OUT, 1'b1, ref_mc(V_OUT, 1'b0));
    drain();

    // backpressure: result held in DONE, then drain overlapped with a new accept
    sel = 2'd0;
    or_mode = 2;
    out_ready = 1'b0;
    send(V_IN, 1'b0, V_OUT);
    n = 0;
    while (!out_valid_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 128'(out_valid_s), 128'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid_s), 128'(1));
      chk("bp_out_state", out_state_s, V_OUT);
      chk("bp_in_ready", 128'(in_ready_s), 128'(0));
    end
    @(posedge clk);
    #1;
    or_mode = 0;
    out_ready = 1'b1;
    send(V_OUT, 1'b1, V_IN);
    drain();

    // reset during the second BUSY cycle discards the in-flight state
    sel = 2'd0;
    send({4{32'h0badf00d}}, 1'b0, 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    chk("midrst_out_valid", 128'(out_valid_s), 128'(0));
    chk("midrst_out_state", out_state_s, 128'(0));
    chk("midrst_in_ready", 128'(in_ready_s), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 128'(in_ready_s), 128'(1));
    @(posedge clk);
    #1;
    send({4{32'h01010101}}, 1'b0, {4{32'h01010101}});
    drain();

    // random traffic with stalls; every tenth item is a forward/inverse round trip
    for (int k = 0; k < NDUT; k++) begin
      sel = 2'(k);
      or_mode = 1;
      for (int i = 0; i < 250; i++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        if ((i % 10) == 0 && inv_en_of(sel)) begin
          f = ref_mc(s, 1'b0);
          send(s, 1'b0, f);
          send(f, 1'b1, s);
        end else begin
          inv = 1'($urandom_range(0, 1));
          send(s, inv, ref_mc(s, inv && inv_en_of(sel)));
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
    end

    chk("leftover_expected", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_mc_iter.md
Name: aes_mc_iter

Overview:
- Iterative MixColumns / InvMixColumns engine for a full 128-bit AES state.
- Processes NCOL columns per cycle, so one state takes 4/NCOL cycles.
- Forward or inverse mode is selected per transaction.
- Sits between the ShiftRows output and the AddRoundKey input in area-constrained (non-masked) datapaths, with valid/ready handshakes on both sides.

Parameters:
- NCOL, 1, columns processed per cycle. Legal values: 1, 2, 4. Any other value is a fatal error at elaboration.
- INV_EN, 1, 1 = inverse mode supported. 0 = `in_inv` is ignored and the inverse logic is removed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input state. Column c = bits [32c+31:32c]; row r of that column = bits [32c+8r+7:32c+8r].
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns. Sampled on the accept cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  result, same layout as `in_state`.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state <- IDLE; in_ready=0 during reset; out_valid=0; out_state=0; column counter=0; mode register=0.
  - Reset mid-operation discards the in-flight state; no partial output is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load `in_state` into the work register, latch `in_inv` into the mode register, clear cnt, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, columns [cnt*NCOL, cnt*NCOL+NCOL-1] of the work register are replaced in place by their transformed values; cnt increments.
  - After the last group (cnt = 4/NCOL-1), go to DONE.
  - For NCOL=4, BUSY lasts exactly one cycle.
- DONE:
  - out_valid=1 and out_state = work register; both are stable while out_ready=0.
  - On out_ready=1: out_valid falls next cycle unless a new result is produced.
  - in_ready = out_ready in DONE, so an accept can overlap with the drain. Then go to BUSY with the new data; otherwise go to IDLE.
- Latency: in accept at cycle t -> out_valid=1 at cycle t+4/NCOL+1 (NCOL=1: 5; NCOL=2: 3; NCOL=4: 2).
- Throughput: one state per 4/NCOL+1 cycles with out_ready held high.
- in_state/in_inv are ignored when in_valid=0 or in_ready=0.
- Column transform (GF(2^8), poly 0x11B; xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0)):
  - Forward:
    - y0 = 2a0^3a1^a2^a3
    - y1 = a0^2a1^3a2^a3
    - y2 = a0^a1^2a2^3a3
    - y3 = 3a0^a1^a2^2a3
  - Inverse: pre-transform, then forward.
    - u = xtime(xtime(a0^a2)); v = xtime(xtime(a1^a3))
    - a0^=u; a1^=v; a2^=u; a3^=v
    - then apply the forward equations.
  - Inverse is selected by the mode register gated by INV_EN.
- No arithmetic overflow is possible; cnt width = clog2(4/NCOL), minimum 1 bit. cnt wraps to 0 on every accept.

Decomposition:
- Shared package aes_mc_pkg:
  - FSM state encoding (IDLE/BUSY/DONE, 2 bits).
  - Localparam AES_POLY = 8'h1B.
  - Function xtime.
  - Constant NB_COL = 4.
- One sub-module: aes_mc_col_dual.
  - Purely combinational single column: 32-bit in, 32-bit out, `inv` input.
  - Parameter INV_EN.
  - Instantiated NCOL times by a generate loop.
  - The column group is selected by an indexed part-select driven by cnt.

Test Plan:
- Forward, NCOL=1: column vector 0x455313db in all 4 columns (bytes db,13,53,45), inv=0 -> each output column 0xbca14d8e. out_valid rises exactly 5 cycles after accept.
- Forward mixed columns, NCOL=2: columns 0x5c220af2, 0xc6c6c6c6, 0xd5d4d4d4, 0x4c31262d -> 0x9d58dc9f, 0xc6c6c6c6, 0xd6d7d5d5, 0xf8bd7e4d. Latency 3.
- Inverse, NCOL=4: feed the outputs of the previous test with inv=1 -> original columns returned. Latency 2. Repeat with INV_EN=0 and inv=1 -> forward result.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state/out_valid stable and in_ready=0. Then assert out_ready together with a new in_valid -> back-to-back accept, next result after 4/NCOL+1 cycles.
- Reset mid-operation: assert rst_n=0 during BUSY cycle 2 (NCOL=1) -> next cycle out_valid=0 and out_state=0; after release, in_ready=1 and a fresh 0x01010101 column state returns unchanged.
- Random: 1000 states with random inv and random out_ready stalls vs. a reference model. Check an inverse-after-forward round-trip is the identity, and no result is lost or duplicated.
